// File: rtl/axi_copy_pkg.sv
// Shared types and constants for the AXI copy scheduler.
package axi_copy_pkg;

  localparam int CPL_STATUS_W = 2;

  localparam logic [CPL_STATUS_W-1:0] ST_OK       = 2'b00;
  localparam logic [CPL_STATUS_W-1:0] ST_ENG_ERR  = 2'b01;
  localparam logic [CPL_STATUS_W-1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [CPL_STATUS_W-1:0] ST_ZERO_LEN = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT     = 3'd2,
    ZLEN     = 3'd3,
    COMPLETE = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The request vector is duplicated so a
// single lowest-bit search starting at the pointer wraps around naturally.
module rr_arbiter
  import axi_copy_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int DW = 2 * NUM_REQ;

  logic [DW-1:0] dbl_req;
  logic [DW-1:0] dbl_mask;
  logic [DW-1:0] cand;
  logic          found;

  assign dbl_req  = {req, req};
  assign dbl_mask = ~((DW'(1) << ptr) - DW'(1));
  assign cand     = dbl_req & dbl_mask;

  // First candidate at or above the pointer, folded back into requester space.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        idx   = IW'(i % NUM_REQ);
      end
    end
    if (found) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_copy_scheduler.sv
// Shares one single-beat AXI copy engine among NUM_REQ requesters: grants one
// descriptor at a time, launches the engine, waits for done or timeout, and
// emits a per-job completion record.
module axi_copy_scheduler
  import axi_copy_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_src,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_dst,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic                            eng_start,
  output logic [ADDR_WIDTH-1:0]           eng_src,
  output logic [ADDR_WIDTH-1:0]           eng_dst,
  output logic [LEN_WIDTH-1:0]            eng_len,
  input  logic                            eng_done,
  input  logic                            eng_error,
  output logic                            cpl_valid,
  output logic [$clog2(NUM_REQ)-1:0]      cpl_id,
  output logic [CPL_STATUS_W-1:0]         cpl_status,
  output logic                            busy,
  output logic                            spurious_done,
  output logic [31:0]                     cpl_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t                state;
  logic [IW-1:0]         cur_id;
  logic [IW-1:0]         rr_ptr;
  logic [TW-1:0]         timer;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic [LEN_WIDTH-1:0]  sel_len;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign sel_len   = req_len[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];
  assign req_ready = (state == IDLE && M_AXI_ARESETN) ? grant : '0;

  // Scheduler FSM with all engine-facing and completion outputs registered.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      cur_id        <= '0;
      rr_ptr        <= '0;
      timer         <= '0;
      eng_start     <= 1'b0;
      eng_src       <= '0;
      eng_dst       <= '0;
      eng_len       <= '0;
      cpl_valid     <= 1'b0;
      cpl_id        <= '0;
      cpl_status    <= ST_OK;
      busy          <= 1'b0;
      spurious_done <= 1'b0;
      cpl_count     <= '0;
    end else begin
      eng_start <= 1'b0;
      cpl_valid <= 1'b0;
      if (eng_done && state != WAIT) begin
        spurious_done <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (|req_valid) begin
            cur_id  <= grant_idx;
            eng_src <= req_src[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            eng_dst <= req_dst[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            eng_len <= sel_len;
            busy    <= 1'b1;
            if (sel_len == '0) begin
              state <= ZLEN;
            end else begin
              state     <= LAUNCH;
              eng_start <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            cpl_status <= eng_error ? ST_ENG_ERR : ST_OK;
            cpl_valid  <= 1'b1;
            cpl_id     <= cur_id;
            cpl_count  <= cpl_count + 32'd1;
            state      <= COMPLETE;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            cpl_status <= ST_TIMEOUT;
            cpl_valid  <= 1'b1;
            cpl_id     <= cur_id;
            cpl_count  <= cpl_count + 32'd1;
            state      <= COMPLETE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ZLEN: begin
          cpl_status <= ST_ZERO_LEN;
          cpl_valid  <= 1'b1;
          cpl_id     <= cur_id;
          cpl_count  <= cpl_count + 32'd1;
          state      <= COMPLETE;
        end
        COMPLETE: begin
          rr_ptr <= (cur_id == IW'(NUM_REQ - 1)) ? '0 : cur_id + IW'(1);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_copy_scheduler.sv
// Self-checking bench for axi_copy_scheduler: directed and randomized jobs
// checked against a cycle-count/priority model of the scheduler's behaviour.
module tb_axi_copy_scheduler;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int LW  = 16;
  localparam int TMO = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_src;
  logic [N*AW-1:0]   req_dst;
  logic [N*LW-1:0]   req_len;
  logic              eng_start;
  logic [AW-1:0]     eng_src;
  logic [AW-1:0]     eng_dst;
  logic [LW-1:0]     eng_len;
  logic              eng_done;
  logic              eng_error;
  logic              cpl_valid;
  logic [1:0]        cpl_id;
  logic [1:0]        cpl_status;
  logic              busy;
  logic              spurious_done;
  logic [31:0]       cpl_count;

  logic [AW-1:0]     src_a [N];
  logic [AW-1:0]     dst_a [N];
  logic [LW-1:0]     len_a [N];

  int                tests_run = 0;
  int                tests_failed = 0;
  int                m_ptr;
  int                m_count;
  bit                m_spur;
  logic [N-1:0]      grant_log [$];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_src[gi*AW +: AW] = src_a[gi];
    assign req_dst[gi*AW +: AW] = dst_a[gi];
    assign req_len[gi*LW +: LW] = len_a[gi];
  end

  axi_copy_scheduler #(
    .NUM_REQ        (N),
    .ADDR_WIDTH     (AW),
    .LEN_WIDTH      (LW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_src       (req_src),
    .req_dst       (req_dst),
    .req_len       (req_len),
    .eng_start     (eng_start),
    .eng_src       (eng_src),
    .eng_dst       (eng_dst),
    .eng_len       (eng_len),
    .eng_done      (eng_done),
    .eng_error     (eng_error),
    .cpl_valid     (cpl_valid),
    .cpl_id        (cpl_id),
    .cpl_status    (cpl_status),
    .busy          (busy),
    .spurious_done (spurious_done),
    .cpl_count     (cpl_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first valid requester at or after the pointer
  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic checkResetValues();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_eng_start", 64'(eng_start), 64'd0);
    checkOutput("rst_cpl_valid", 64'(cpl_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_spurious", 64'(spurious_done), 64'd0);
    checkOutput("rst_eng_src", 64'(eng_src), 64'd0);
    checkOutput("rst_eng_dst", 64'(eng_dst), 64'd0);
    checkOutput("rst_eng_len", 64'(eng_len), 64'd0);
    checkOutput("rst_cpl_id", 64'(cpl_id), 64'd0);
    checkOutput("rst_cpl_status", 64'(cpl_status), 64'd0);
    checkOutput("rst_cpl_count", 64'(cpl_count), 64'd0);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req_valid = '0;
    eng_done  = 1'b0;
    eng_error = 1'b0;
    #1;
    checkResetValues();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("cpl_during_reset", 64'(cpl_valid), 64'd0);
    end
    rst_n   = 1'b1;
    m_ptr   = 0;
    m_count = 0;
    m_spur  = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 64 && busy !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("idle_wait", 64'(busy), 64'd0);
  endtask

  // One job: present vmask, engine answers d cycles after eng_start (0 = never)
  task automatic applyStimulus(input logic [N-1:0] vmask, input bit keep, input int d, input bit err);
    int           g;
    logic [N-1:0] exp_rdy;
    bit           zl;
    int           exp_rel;
    int           last_rel;
    logic [1:0]   exp_st;
    waitIdle();
    req_valid = vmask;
    #1;
    g = model_grant(vmask, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_rdy));
    grant_log.push_back(req_ready);
    if (g < 0) begin
      req_valid = '0;
      return;
    end
    zl = (len_a[g] == '0);
    @(posedge clk); #1;
    if (!keep) req_valid = '0;
    checkOutput("eng_start", 64'(eng_start), 64'(!zl));
    checkOutput("busy_after_grant", 64'(busy), 64'd1);
    checkOutput("ready_outside_idle", 64'(req_ready), 64'd0);
    if (!zl) begin
      checkOutput("eng_src", 64'(eng_src), 64'(src_a[g]));
      checkOutput("eng_dst", 64'(eng_dst), 64'(dst_a[g]));
      checkOutput("eng_len", 64'(eng_len), 64'(len_a[g]));
    end
    if (zl) begin
      exp_rel = 1;
      exp_st  = 2'b11;
    end else if (d >= 1 && d <= TMO) begin
      exp_rel = d + 1;
      exp_st  = err ? 2'b01 : 2'b00;
    end else begin
      exp_rel = TMO + 1;
      exp_st  = 2'b10;
    end
    last_rel = (!zl && d > 0 && d >= exp_rel) ? d + 1 : exp_rel;
    for (int r = 1; r <= last_rel; r++) begin
      @(posedge clk); #1;
      eng_done  = (!zl && d > 0 && r == d);
      eng_error = eng_done & err;
      checkOutput("cpl_valid", 64'(cpl_valid), 64'(r == exp_rel));
      if (r == exp_rel) begin
        checkOutput("cpl_id", 64'(cpl_id), 64'(g));
        checkOutput("cpl_status", 64'(cpl_status), 64'(exp_st));
        checkOutput("cpl_count", 64'(cpl_count), 64'(m_count + 1));
      end
    end
    if (!zl && d > TMO) m_spur = 1'b1;
    checkOutput("spurious_done", 64'(spurious_done), 64'(m_spur));
    m_count++;
    m_ptr = (g + 1) % N;
  endtask

  initial begin
    logic [N-1:0] exp_oh;
    int           cnt;
    rst_n     = 1'b1;
    req_valid = '0;
    eng_done  = 1'b0;
    eng_error = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_a[i] = '0;
      dst_a[i] = '0;
      len_a[i] = '0;
    end
    #1;
    doReset();

    // Single requester, normal completion 20 cycles after start
    src_a[0] = 32'h0000_1000;
    dst_a[0] = 32'h0000_2000;
    len_a[0] = 16'd64;
    applyStimulus(4'b0001, 1'b0, 20, 1'b0);

    // All requesters continuously valid: one grant each per round
    @(posedge clk); #1;
    doReset();
    for (int i = 0; i < N; i++) begin
      src_a[i] = $urandom;
      dst_a[i] = $urandom;
      len_a[i] = LW'($urandom_range(1, 65535));
    end
    grant_log.delete();
    for (int j = 0; j < 5; j++) applyStimulus(4'b1111, 1'b1, 3, 1'b0);
    req_valid = '0;
    for (int j = 0; j < 5; j++) begin
      exp_oh = '0;
      exp_oh[j % N] = 1'b1;
      checkOutput("rr_order", 64'(grant_log[j]), 64'(exp_oh));
    end
    for (int r = 0; r < N; r++) begin
      cnt = 0;
      for (int j = 0; j < N; j++) if (grant_log[j][r]) cnt++;
      checkOutput("rr_once_per_round", 64'(cnt), 64'd1);
    end

    // Zero-length job on requester 2, then priority moves on to requester 3
    len_a[2] = '0;
    applyStimulus(4'b0100, 1'b0, 0, 1'b0);
    applyStimulus(4'b1001, 1'b0, 5, 1'b0);

    // Engine never answers: timeout, then a late done is flagged as spurious
    applyStimulus(4'b0001, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    m_spur   = 1'b1;
    checkOutput("spurious_after_timeout", 64'(spurious_done), 64'd1);
    checkOutput("no_cpl_on_spurious", 64'(cpl_valid), 64'd0);

    // Error done in the very cycle the timer expires: done wins
    applyStimulus(4'b0010, 1'b0, TMO, 1'b1);

    // Randomized jobs: masks, descriptors, zero lengths, latencies, errors
    for (int j = 0; j < 14; j++) begin
      for (int i = 0; i < N; i++) begin
        src_a[i] = $urandom;
        dst_a[i] = $urandom;
        len_a[i] = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 65535));
      end
      applyStimulus(N'($urandom_range(1, 15)), 1'b0, $urandom_range(0, TMO + 3),
                    1'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT: job abandoned, outputs back to reset values
    waitIdle();
    len_a[1]  = 16'd100;
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("busy_before_reset", 64'(busy), 64'd1);
    doReset();
    len_a[0] = 16'd8;
    len_a[2] = 16'd8;
    applyStimulus(4'b0101, 1'b0, 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
